// File: rtl/ccff_loader_pkg.sv
// Shared state encoding and CRC-8 constants for the configuration-chain loader.
package ccff_loader_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CHECK, FINISH} state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
endpackage

// File: rtl/ccff_chain_loader_if.sv
// Stream, control and chain signals of the loader; master is the producer/bench side.
// tail_parity is present only when CCFF_LOADER_CRC_EN is defined.
interface ccff_chain_loader_if #(parameter int WORD_W = 8);
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              config_enable;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic              error;
`ifdef CCFF_LOADER_CRC_EN
  logic              tail_parity;

  modport master (output start, abort, cfg_data, cfg_valid, ccff_tail,
                  input  cfg_ready, ccff_head, config_enable, busy, done, error, tail_parity);
  modport slave  (input  start, abort, cfg_data, cfg_valid, ccff_tail,
                  output cfg_ready, ccff_head, config_enable, busy, done, error, tail_parity);
`else
  modport master (output start, abort, cfg_data, cfg_valid, ccff_tail,
                  input  cfg_ready, ccff_head, config_enable, busy, done, error);
  modport slave  (input  start, abort, cfg_data, cfg_valid, ccff_tail,
                  output cfg_ready, ccff_head, config_enable, busy, done, error);
`endif
endinterface

// File: rtl/ccff_crc8.sv
// Serial CRC-8 (MSB-first register), one input bit per enabled cycle.
module ccff_crc8
  import ccff_loader_pkg::*;
(
  input  logic       prog_clk,
  input  logic       pReset,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);
  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[7] ^ bit_in;
    if (clr)     crc_d = CRC8_INIT;
    else if (en) crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) crc_q <= CRC8_INIT;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;
endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises a word stream LSB-first onto one ccff_head/ccff_tail chain segment.
// CCFF_LOADER_CRC_EN adds a CRC-8 over shifted bits, checked against a trailer word.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  ccff_chain_loader_if.slave bus
);
  localparam int BW = $clog2(WORD_W + 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bits_q, bits_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              err_q, err_d;

`ifdef CCFF_LOADER_CRC_EN
  logic [7:0] crc;
  logic       tail_parity_q;

  ccff_crc8 u_crc (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .clr      ((state_q == IDLE) && bus.start),
    .en       (state_q == SHIFT),
    .bit_in   (shreg_q[0]),
    .crc      (crc)
  );

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset)                              tail_parity_q <= 1'b0;
    else if ((state_q == IDLE) && bus.start) tail_parity_q <= 1'b0;
    else if (state_q == SHIFT)               tail_parity_q <= tail_parity_q ^ bus.ccff_tail;
  end

  assign bus.tail_parity = tail_parity_q;
  assign bus.cfg_ready   = (state_q == LOAD) || (state_q == CHECK);
`else
  logic unused_tail;
  assign unused_tail   = bus.ccff_tail;
  assign bus.cfg_ready = (state_q == LOAD);
`endif

  assign bus.ccff_head     = shreg_q[0];
  assign bus.config_enable = (state_q == SHIFT);
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == FINISH);
  assign bus.error         = err_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bits_d  = bits_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = LOAD;
        rem_d   = CNT_W'(CHAIN_LEN);
        err_d   = 1'b0;
      end
      LOAD: if (bus.abort) begin
        state_d = FINISH;
        err_d   = 1'b1;
      end else if (bus.cfg_valid) begin
        shreg_d = bus.cfg_data;
        bits_d  = (rem_q >= CNT_W'(WORD_W)) ? BW'(WORD_W) : BW'(rem_q);
        state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = shreg_q >> 1;
        bits_d  = bits_q - BW'(1);
        rem_d   = rem_q - CNT_W'(1);
        if (bits_q == BW'(1)) begin
          // word exhausted: flush leftover upper bits so they never reach ccff_head
          shreg_d = '0;
          if (rem_q == CNT_W'(1)) begin
`ifdef CCFF_LOADER_CRC_EN
            state_d = CHECK;
`else
            state_d = FINISH;
`endif
          end else begin
            state_d = LOAD;
          end
        end
        if (bus.abort) begin
          state_d = FINISH;
          err_d   = 1'b1;
          shreg_d = '0;
        end
      end
`ifdef CCFF_LOADER_CRC_EN
      CHECK: if (bus.abort) begin
        state_d = FINISH;
        err_d   = 1'b1;
      end else if (bus.cfg_valid) begin
        if (bus.cfg_data[7:0] != crc) err_d = 1'b1;
        state_d = FINISH;
      end
`endif
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bits_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bits_q  <= bits_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: CHAIN_LEN=4 and 20 loaders (plus CHAIN_LEN=8 with CCFF_LOADER_CRC_EN),
// sharing stimulus; only the selected loader sees start and drives the observed outputs.
module tb_ccff_chain_loader;
  logic       prog_clk = 1'b0;
  logic       pReset   = 1'b1;
  logic       start = 1'b0, abort = 1'b0, cfg_valid = 1'b0, tail = 1'b0;
  logic [7:0] cfg_data = '0;
  int         sel = 0;
  int         n_chk = 0, n_err = 0;
  bit         cap[$];

`ifdef CCFF_LOADER_CRC_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader_if #(.WORD_W(8)) ifa ();
  ccff_chain_loader_if #(.WORD_W(8)) ifb ();
  assign ifa.start = start && (sel == 0);
  assign ifb.start = start && (sel == 1);
  assign {ifa.abort, ifa.cfg_valid, ifa.cfg_data, ifa.ccff_tail} = {abort, cfg_valid, cfg_data, tail};
  assign {ifb.abort, ifb.cfg_valid, ifb.cfg_data, ifb.ccff_tail} = {abort, cfg_valid, cfg_data, tail};

  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(4),  .CNT_W(16)) u_a (.prog_clk(prog_clk), .pReset(pReset), .bus(ifa));
  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(20), .CNT_W(16)) u_b (.prog_clk(prog_clk), .pReset(pReset), .bus(ifb));

`ifdef CCFF_LOADER_CRC_EN
  ccff_chain_loader_if #(.WORD_W(8)) ifc ();
  assign ifc.start = start && (sel == 2);
  assign {ifc.abort, ifc.cfg_valid, ifc.cfg_data, ifc.ccff_tail} = {abort, cfg_valid, cfg_data, tail};
  ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(8), .CNT_W(16)) u_c (.prog_clk(prog_clk), .pReset(pReset), .bus(ifc));
`endif

  logic o_rdy, o_head, o_en, o_busy, o_done, o_err;
  always_comb begin
    {o_rdy, o_head, o_en, o_busy, o_done, o_err} =
      {ifa.cfg_ready, ifa.ccff_head, ifa.config_enable, ifa.busy, ifa.done, ifa.error};
    if (sel == 1)
      {o_rdy, o_head, o_en, o_busy, o_done, o_err} =
        {ifb.cfg_ready, ifb.ccff_head, ifb.config_enable, ifb.busy, ifb.done, ifb.error};
`ifdef CCFF_LOADER_CRC_EN
    if (sel == 2)
      {o_rdy, o_head, o_en, o_busy, o_done, o_err} =
        {ifc.cfg_ready, ifc.ccff_head, ifc.config_enable, ifc.busy, ifc.done, ifc.error};
`endif
  end

  // record every chain bit actually shifted, sampled at the edge that consumes it
  always @(posedge prog_clk) if (o_en) cap.push_back(o_head);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge prog_clk);
  endtask

  function automatic logic [7:0] crc8_model(input logic [31:0] v, input int n);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb = c[7] ^ v[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  function automatic logic [31:0] cap_val(input int base, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = cap[base + i];
    return v;
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int stall);
    int n;
    n = 0;
    while (!o_rdy && n < 64) begin tick(); n++; end
    chk("rdy_wait", o_rdy, 1);
    repeat (stall) tick();
    if (stall > 0) begin
      chk("stall_en", o_en, 0);
      chk("stall_rdy", o_rdy, 1);
    end
    cfg_valid = 1'b1;
    cfg_data  = w;
    tick();
    cfg_valid = 1'b0;
  endtask

  // runs until done, answering a CHECK-state trailer request if one appears
  task automatic finish_load(input logic [7:0] trailer, output int ncyc);
    bit sent;
    sent = 1'b0;
    ncyc = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      ncyc++;
      cfg_valid = 1'b0;
      if (o_done) break;
      if (o_rdy && !sent) begin
        cfg_valid = 1'b1;
        cfg_data  = trailer;
        sent      = 1'b1;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int          base, ncyc, cnt;
    logic [3:0]  exp_bits;
    logic [31:0] v;

    // reset state
    #1;
    chk("rst_a", {ifa.cfg_ready, ifa.ccff_head, ifa.config_enable, ifa.busy, ifa.done, ifa.error}, 0);
    chk("rst_b", {ifb.cfg_ready, ifb.ccff_head, ifb.config_enable, ifb.busy, ifb.done, ifb.error}, 0);
    tick(); tick();
    pReset = 1'b0;
    tick();

    // CHAIN_LEN=4, 0xA5: 1,0,1,0 then done; upper nibble never shifted
    sel = 0;
    base = cap.size();
    do_start();
    chk("t1_busy", o_busy, 1);
    chk("t1_rdy", o_rdy, 1);
    chk("t1_en_load", o_en, 0);
    send_word(8'hA5, 0);
    exp_bits = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      chk("t1_en", o_en, 1);
      chk("t1_head", o_head, exp_bits[i]);
      if (i < 3) tick();
    end
    finish_load(crc8_model(32'hA5, 4), ncyc);
    chk("t1_done_lat", ncyc, 1 + EXTRA);
    chk("t1_done", o_done, 1);
    chk("t1_en_fin", o_en, 0);
    chk("t1_head_fin", o_head, 0);
    chk("t1_err", o_err, 0);
    chk("t1_count", cap.size() - base, 4);
    tick();
    chk("t1_idle", {o_busy, o_done}, 0);

    // CHAIN_LEN=20: 0xFF, 0x00, 0x3C with a 5-cycle stall before the third word
    sel = 1;
    base = cap.size();
    do_start();
    send_word(8'hFF, 0);
    send_word(8'h00, 0);
    send_word(8'h3C, 5);
    finish_load(crc8_model(32'hC00FF, 20), ncyc);
    chk("t2_done", o_done, 1);
    cnt = cap.size() - base;
    chk("t2_count", cnt, 20);
    v = cap_val(base, 20);
    chk("t2_bits", v, 32'hC00FF);
    chk("t2_bits16_19", (v >> 16) & 32'hF, 32'hC);
    chk("t2_err", o_err, 0);
    tick();
    chk("t2_idle", o_busy, 0);

    // abort on the second SHIFT cycle
    sel = 0;
    base = cap.size();
    do_start();
    send_word(8'hA5, 0);
    tick();
    chk("t3_en_shift2", o_en, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t3_en_drop", o_en, 0);
    chk("t3_done", o_done, 1);
    chk("t3_err", o_err, 1);
    chk("t3_count", cap.size() - base, 2);
    tick();
    chk("t3_idle", {o_busy, o_done}, 0);
    chk("t3_err_sticky", o_err, 1);

    // next start clears error; then reset mid-SHIFT
    do_start();
    chk("t4_err_clr", o_err, 0);
    send_word(8'hA5, 0);
    tick();
    chk("t4_en_pre", o_en, 1);
    pReset = 1'b1;
    #1;
    chk("t4_async_rst", {o_rdy, o_head, o_en, o_busy, o_done, o_err}, 0);
    tick();
    pReset = 1'b0;
    tick();

    // fresh load after reset, with a start pulse during SHIFT that must be ignored
    base = cap.size();
    do_start();
    send_word(8'hA5, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("t5_en_last", o_en, 1);
    finish_load(crc8_model(32'hA5, 4), ncyc);
    chk("t5_done_lat", ncyc, 1 + EXTRA);
    chk("t5_done", o_done, 1);
    chk("t5_err", o_err, 0);
    chk("t5_count", cap.size() - base, 4);
    chk("t5_bits", cap_val(base, 4), 32'h5);
    tick();
    chk("t5_idle", o_busy, 0);
    tick();
    chk("t5_no_restart", o_busy, 0);

`ifdef CCFF_LOADER_CRC_EN
    // CRC trailer: correct then corrupted
    sel = 2;
    do_start();
    send_word(8'h5A, 0);
    finish_load(crc8_model(32'h5A, 8), ncyc);
    chk("t6_done_good", o_done, 1);
    chk("t6_err_good", o_err, 0);
    tick();
    do_start();
    send_word(8'h5A, 0);
    finish_load(crc8_model(32'h5A, 8) ^ 8'h01, ncyc);
    chk("t6_done_bad", o_done, 1);
    chk("t6_err_bad", o_err, 1);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
